// File: rtl/ctrl_seq.sv
// Instruction sequencer: program counter, request/valid fetch, one-cycle execute with
// ALU control decode, jumps, zero-flag branch and halt.
module ctrl_seq #(
    parameter int unsigned ADDRESS_BITS = 5,
    parameter int unsigned INSTR_BITS   = 3,
    localparam int unsigned VALUE_BITS  = INSTR_BITS + ADDRESS_BITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [VALUE_BITS-1:0]   value,
    input  logic                    i_valid,
    input  logic                    zero,
    output logic [ADDRESS_BITS-1:0] o_pc,
    output logic                    o_fetch,
    output logic [ADDRESS_BITS-1:0] o_address,
    output logic [7:0]              o_instr,
    output logic                    o_store,
    output logic                    o_busy,
    output logic                    o_halt,
    output logic                    o_illegal
);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

    localparam logic [ADDRESS_BITS-1:0] PcOne = 1;

    state_e                  state;
    logic [ADDRESS_BITS-1:0] pc;
    logic [INSTR_BITS-1:0]   op;
    logic                    en_low;
    logic                    en_rise;
    logic [INSTR_BITS-1:0]   fetch_op;
    logic                    op_legal;

    // en_low resets to 0 so an enable already high at reset release is not an edge
    assign en_rise  = enable & en_low;
    assign fetch_op = value[VALUE_BITS-1:ADDRESS_BITS];
    assign op_legal = (op >> 3) == '0;
    assign o_pc     = pc;

    function automatic logic [7:0] ctrl_word(input logic [INSTR_BITS-1:0] opc);
        logic [7:0] w;
        w = 8'hFF;
        if ((opc >> 3) == '0) begin
            case (opc[2:0])
                3'd1:    w = 8'h00;
                3'd2:    w = 8'h02;
                3'd3:    w = 8'h03;
                3'd4:    w = 8'h01;
                default: w = 8'hFF;
            endcase
        end
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            pc        <= '0;
            op        <= '0;
            en_low    <= 1'b0;
            o_fetch   <= 1'b0;
            o_address <= '0;
            o_instr   <= 8'hFF;
            o_store   <= 1'b0;
            o_busy    <= 1'b0;
            o_halt    <= 1'b0;
            o_illegal <= 1'b0;
        end else begin
            en_low <= ~enable;
            case (state)
                StIdle, StHalt: begin
                    if (en_rise) begin
                        state     <= StFetch;
                        pc        <= '0;
                        o_illegal <= 1'b0;
                        o_fetch   <= 1'b1;
                        o_busy    <= 1'b1;
                        o_halt    <= 1'b0;
                    end
                end
                StFetch: begin
                    if (i_valid) begin
                        state     <= StExec;
                        op        <= fetch_op;
                        o_fetch   <= 1'b0;
                        o_address <= value[ADDRESS_BITS-1:0];
                        o_instr   <= ctrl_word(fetch_op);
                        o_store   <= ((fetch_op >> 3) == '0) && (fetch_op[2:0] == 3'd4);
                    end
                end
                StExec: begin
                    o_instr <= 8'hFF;
                    o_store <= 1'b0;
                    if (!op_legal) begin
                        state     <= StHalt;
                        o_illegal <= 1'b1;
                        o_halt    <= 1'b1;
                        o_busy    <= 1'b0;
                    end else if (op[2:0] == 3'd7) begin
                        state  <= StHalt;
                        o_halt <= 1'b1;
                        o_busy <= 1'b0;
                    end else begin
                        state   <= StFetch;
                        o_fetch <= 1'b1;
                        // o_address still holds the operand of the executing word
                        if (op[2:0] == 3'd5 || (op[2:0] == 3'd6 && zero)) begin
                            pc <= o_address;
                        end else begin
                            pc <= pc + PcOne;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Randomised and directed bench for ctrl_seq against an instruction-level model.
module tb_ctrl_seq;

    localparam int AB = 5;
    localparam int IB = 4;
    localparam int VB = AB + IB;

    localparam int MIdle  = 0;
    localparam int MFetch = 1;
    localparam int MExec  = 2;
    localparam int MHalt  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [VB-1:0] value = '0;
    logic          i_valid = 1'b0;
    logic          zero = 1'b0;
    logic [AB-1:0] o_pc;
    logic          o_fetch;
    logic [AB-1:0] o_address;
    logic [7:0]    o_instr;
    logic          o_store;
    logic          o_busy;
    logic          o_halt;
    logic          o_illegal;

    int vectors = 0;
    int errors  = 0;

    logic [VB-1:0] mem [32];
    logic [7:0]    ctrl_tab [8];

    int            m_mode;
    int            m_pc;
    logic [VB-1:0] m_word;
    logic          m_ill;
    logic          m_en_prev;

    ctrl_seq #(.ADDRESS_BITS(AB), .INSTR_BITS(IB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .value     (value),
        .i_valid   (i_valid),
        .zero      (zero),
        .o_pc      (o_pc),
        .o_fetch   (o_fetch),
        .o_address (o_address),
        .o_instr   (o_instr),
        .o_store   (o_store),
        .o_busy    (o_busy),
        .o_halt    (o_halt),
        .o_illegal (o_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [VB-1:0] w(input int opc, input int opnd);
        return VB'((opc << AB) | opnd);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode    = MIdle;
        m_pc      = 0;
        m_word    = '0;
        m_ill     = 1'b0;
        m_en_prev = 1'b1;  // unknown history counts as high: no edge at release
    endtask

    task automatic model_step();
        int  opc;
        int  opnd;
        logic rise;
        rise      = enable && !m_en_prev;
        m_en_prev = enable;
        opc       = int'(m_word) >> AB;
        opnd      = int'(m_word) % 32;
        if (m_mode == MIdle || m_mode == MHalt) begin
            if (rise) begin
                m_mode = MFetch;
                m_pc   = 0;
                m_ill  = 1'b0;
            end
        end else if (m_mode == MFetch) begin
            if (i_valid) begin
                m_word = value;
                m_mode = MExec;
            end
        end else begin
            if (opc > 7) begin
                m_ill  = 1'b1;
                m_mode = MHalt;
            end else if (opc == 7) begin
                m_mode = MHalt;
            end else begin
                m_mode = MFetch;
                if (opc == 5 || (opc == 6 && zero)) m_pc = opnd;
                else m_pc = (m_pc + 1) % 32;
            end
        end
    endtask

    task automatic compare_all(input string name);
        int opc;
        logic [17:0] got;
        logic [17:0] exp;
        logic [7:0] e_instr;
        logic e_store;
        opc     = int'(m_word) >> AB;
        e_instr = 8'hFF;
        e_store = 1'b0;
        if (m_mode == MExec) begin
            if (opc < 8) e_instr = ctrl_tab[opc];
            e_store = (opc == 4);
        end
        exp = {AB'(m_pc), m_mode == MFetch, e_instr, e_store,
               m_mode == MFetch || m_mode == MExec, m_mode == MHalt, m_ill};
        got = {o_pc, o_fetch, o_instr, o_store, o_busy, o_halt, o_illegal};
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: {pc,fetch,instr,store,busy,halt,ill} got %h expected %h",
                     name, $time, got, exp);
        end
        if (m_mode == MExec) chk({name, "_addr"}, int'(o_address), int'(m_word) % 32);
    endtask

    task automatic step(input logic en, input logic iv, input logic z);
        enable  = en;
        i_valid = iv;
        zero    = z;
        value   = (m_mode == MFetch) ? mem[m_pc] : VB'($urandom);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all("cycle");
        vectors++;
    endtask

    // Reset pulse lands mid-cycle, away from any clock edge
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all("async_rst");
        chk("rst_store", int'(o_store), 0);
        chk("rst_instr", int'(o_instr), 8'hFF);
        @(posedge clk);
        @(negedge clk);
        compare_all("in_rst");
        #1 rst_n = 1'b1;
    endtask

    task automatic start();
        pulse_reset();
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        ctrl_tab = '{8'hFF, 8'h00, 8'h02, 8'h03, 8'h01, 8'hFF, 8'hFF, 8'hFF};
        for (int i = 0; i < 32; i++) mem[i] = '0;
        model_reset();
        @(negedge clk);
        compare_all("por");
        chk("por_instr", int'(o_instr), 8'hFF);
        #1 rst_n = 1'b1;

        // Enable held high across release is no edge; i_valid in IDLE ignored
        enable = 1'b1;
        pulse_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("no_edge_busy", int'(o_busy), 0);
        chk("idle_fetch", int'(o_fetch), 0);

        // LD 3, ADD 4, STO 5, HLT
        mem[0] = w(1, 3); mem[1] = w(2, 4); mem[2] = w(4, 5); mem[3] = w(7, 0);
        start();
        chk("a_c1_fetch", int'(o_fetch), 1);
        step(1'b1, 1'b1, 1'b0);
        chk("a_c2_instr", int'(o_instr), 8'h00);
        chk("a_c2_store", int'(o_store), 0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("a_c4_instr", int'(o_instr), 8'h02);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("a_c6_instr", int'(o_instr), 8'h01);
        chk("a_c6_store", int'(o_store), 1);
        chk("a_c6_addr", int'(o_address), 5);
        step(1'b1, 1'b1, 1'b0);
        chk("a_c7_store", int'(o_store), 0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("a_halt", int'(o_halt), 1);
        chk("a_halt_pc", int'(o_pc), 3);

        // Restart from HALT, enable toggled mid-run, reset during the STO execute
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("a2_c1_pc", int'(o_pc), 0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("a2_c6_store", int'(o_store), 1);
        pulse_reset();

        // Jumps, branch taken and not taken, pc wrap
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[0] = w(5, 7); mem[7] = w(6, 10); mem[8] = w(6, 10); mem[10] = w(5, 31);
        start();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("b_jmp7", int'(o_pc), 7);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("b_jz_nt", int'(o_pc), 8);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("b_jz_t", int'(o_pc), 10);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("b_jmp31", int'(o_pc), 31);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("b_nop_wrap", int'(o_pc), 0);

        mem[0] = w(5, 31); mem[31] = w(5, 0);
        start();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("c_pc31", int'(o_pc), 31);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("c_jmp0", int'(o_pc), 0);

        // i_valid withheld three cycles
        mem[0] = w(1, 3);
        pulse_reset();
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("d_hold_fetch", int'(o_fetch), 1);
            chk("d_hold_pc", int'(o_pc), 0);
        end
        step(1'b1, 1'b1, 1'b0);
        chk("d_exec_instr", int'(o_instr), 8'h00);

        // Illegal opcode 1001 then restart
        mem[0] = w(9, 2);
        start();
        step(1'b1, 1'b1, 1'b0);
        chk("e_instr", int'(o_instr), 8'hFF);
        step(1'b1, 1'b1, 1'b0);
        chk("e_ill", int'(o_illegal), 1);
        chk("e_halt", int'(o_halt), 1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("e_ill_clr", int'(o_illegal), 0);
        chk("e_refetch", int'(o_fetch), 1);
        chk("e_pc0", int'(o_pc), 0);

        // Random programs, handshake delays, flags, enable activity and resets
        for (int i = 0; i < 32; i++) begin
            if ($urandom_range(0, 99) < 6) mem[i] = w($urandom_range(8, 15), $urandom_range(0, 31));
            else mem[i] = w($urandom_range(0, 7), $urandom_range(0, 31));
        end
        for (int n = 0; n < 4000; n++) begin
            logic en;
            en = enable;
            if ($urandom_range(0, 7) == 0) en = ~en;
            step(en, $urandom_range(0, 3) != 0, 1'($urandom));
            if ($urandom_range(0, 499) == 0) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Parametrised instruction sequencer: the successor to the single-shot ISA decoder and line controller. It owns a program counter, fetches instruction words through a request/valid handshake, decodes them into ALU control, register-line address and store strobe, and handles jumps, a conditional branch on the ALU zero flag, and halt. It sits between instruction memory and the ALU/register-file datapath.

## Interface
- ADDRESS_BITS, 5, width of the operand address field and of the program counter
- INSTR_BITS, 3, width of the opcode field (minimum 3); VALUE_BITS = INSTR_BITS + ADDRESS_BITS
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  start request; a rising edge, sampled synchronously, starts or restarts execution
- value  in  VALUE_BITS  instruction word: opcode in [VALUE_BITS-1:ADDRESS_BITS], operand in [ADDRESS_BITS-1:0]
- i_valid  in  1  instruction word on `value` is valid
- zero  in  1  ALU zero flag
- o_pc  out  ADDRESS_BITS  fetch address
- o_fetch  out  1  fetch request
- o_address  out  ADDRESS_BITS  register-line address for the executing instruction
- o_instr  out  8  ALU control word
- o_store  out  1  one-cycle write strobe
- o_busy  out  1  high in FETCH and EXEC
- o_halt  out  1  high in HALT
- o_illegal  out  1  sticky; set when HALT is entered on an illegal opcode

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- Reset values: state IDLE, pc 0, o_pc 0, o_fetch 0, o_address 0, o_instr 8'hFF, o_store 0, o_busy 0, o_halt 0, o_illegal 0, enable-edge register 0.
- IDLE or HALT, enable rising edge: pc <= 0, o_illegal <= 0, go to FETCH. Enable edges in FETCH or EXEC are ignored.
- FETCH: o_fetch = 1 and o_pc = pc, held until i_valid. The word is captured on the edge where o_fetch && i_valid, then the block goes to EXEC. i_valid outside FETCH is ignored.
- EXEC, one cycle. o_address = operand. o_instr and o_store are driven only here; outside EXEC, o_instr = 8'hFF and o_store = 0.
- Opcode decode. Opcode bits above bit 2 must be 0, otherwise the opcode is illegal.
  - 000 NOP: o_instr 8'hFF; pc+1.
  - 001 LD: o_instr 8'h00; pc+1.
  - 010 ADD: o_instr 8'h02; pc+1.
  - 011 SUB: o_instr 8'h03; pc+1.
  - 100 STO: o_instr 8'h01, o_store 1; pc+1.
  - 101 JMP: o_instr 8'hFF; pc <= operand.
  - 110 JZ: o_instr 8'hFF; pc <= operand if zero = 1 in the EXEC cycle, else pc+1.
  - 111 HLT: o_instr 8'hFF; go to HALT; pc unchanged.
  - Illegal: o_instr 8'hFF, o_illegal <= 1, go to HALT.
- After EXEC the block goes to FETCH, except for HLT and illegal opcodes.
- pc arithmetic is modulo 2^ADDRESS_BITS: pc+1 from all-ones wraps to 0 with no flag.

## Timing
- Enable edge detect: enable = 1 at edge k with enable = 0 at edge k-1 means FETCH is active from edge k (o_fetch high in cycle k+1).
- If i_valid is high in the first FETCH cycle, EXEC follows next cycle. Minimum throughput is 2 cycles per instruction; each cycle of i_valid delay adds one cycle.
- o_store is exactly one cycle wide, coincident with EXEC; o_address and o_instr are valid in that same cycle.
- HALT holds o_halt = 1 until the next enable rising edge.
- rst_n low at any time, including mid-FETCH and mid-EXEC (with o_store high), forces the reset values immediately and asynchronously. First operation after release needs a fresh enable rising edge; an enable already high at release is not an edge.

## Test plan
- Program LD 3, ADD 4, STO 5, HLT with i_valid always high -> o_instr 00, 02, 01 in cycles 2, 4, 6 after start; o_store high only in cycle 6 with o_address 5; then o_halt = 1 and o_pc = 3.
- JZ 10 with zero = 1 -> next o_pc = 10. JZ 10 with zero = 0 at pc 7 -> next o_pc = 8. JMP 0 at pc 31 -> o_pc = 0. NOP at pc 31 -> o_pc wraps to 0.
- i_valid withheld 3 cycles -> o_fetch and o_pc held stable for 4 cycles, no EXEC in that time. i_valid pulsed in IDLE -> no state change.
- INSTR_BITS = 4, opcode 1001 -> o_illegal = 1 and o_halt = 1. A following enable rising edge -> o_illegal cleared, fetch restarts at pc 0.
- Enable toggled during FETCH and EXEC -> ignored. rst_n pulsed low during an EXEC cycle with o_store high -> o_store drops immediately and all outputs take reset values.
